lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Parametrised, multi-cycle successor to the combinational MEM-stage memory access.
- Accepts one load/store per handshake from EX and detects misalignment (ALE).
- Drives a valid/ready request/response data bus with byte strobes, then returns aligned, sign- or zero-extended load data to WB.
- Allows one outstanding access. Holds the pipeline via in_ready until the access completes.

Parameters:
- DATA_W, 32, bus and register data width. Legal values are 32 and 64.
- ADDR_W, 32, address width.
- NBYTES, DATA_W/8, byte lanes. This is derived and must not be overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  EX offers an op
- in_ready  out  1  unit accepts the op
- in_lsu_op  in  4  op code (see Behaviour)
- in_addr  in  ADDR_W  effective address
- in_wdata  in  DATA_W  store data, LSB-justified
- in_flush  in  1  kill the in-flight op
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts the request
- req_we  out  1  1 = write
- req_addr  out  ADDR_W  address aligned to NBYTES
- req_wdata  out  DATA_W  lane-shifted store data
- req_wstrb  out  NBYTES  byte strobes
- resp_valid  in  1  bus response, one cycle
- resp_rdata  in  DATA_W  read data for the aligned word
- out_valid  out  1  result valid
- out_ready  in  1  WB accepts the result
- out_rdata  out  DATA_W  extended load data; 0 for stores
- out_ale  out  1  misaligned-address exception
- out_badv  out  ADDR_W  faulting address, valid when out_ale=1
- busy  out  1  FSM not in IDLE

Behaviour:
- Op encoding:
  - 0000 LD.B, 0001 LD.H, 0010 LD.W, 0011 LD.D (DATA_W=64 only)
  - 1000 LD.BU, 1001 LD.HU, 1010 LD.WU (DATA_W=64 only)
  - 0100 ST.B, 0101 ST.H, 0110 ST.W, 0111 ST.D (DATA_W=64 only)
  - 1111 NOP. Any other code is treated as NOP.
- Access size: sz = 1/2/4/8 bytes. Misaligned when addr mod sz != 0.
- FSM states: IDLE, REQ, RESP, DONE, DRAIN.
- in_ready=1 only in IDLE. Accept = in_valid & in_ready. Op, addr and wdata are registered on accept.
- IDLE transitions on accept:
  - NOP or misaligned -> DONE.
  - Otherwise -> REQ.
  - No bus request is ever issued for a misaligned op.
- REQ:
  - req_valid=1; req_* are driven from registers and stay stable while req_ready=0.
  - On req_valid & req_ready -> RESP.
  - On in_flush -> IDLE with no bus transaction. Flush takes priority over req_ready in the same cycle.
- RESP:
  - On resp_valid: capture and extend data -> DONE.
  - On in_flush (without resp_valid) -> DRAIN.
  - If in_flush and resp_valid arrive in the same cycle -> IDLE; the result is discarded.
- DRAIN: wait for resp_valid, discard the data -> IDLE. out_valid stays 0.
- DONE:
  - out_valid=1; out_* are held stable until out_ready.
  - On out_ready -> IDLE.
  - On in_flush -> IDLE and out_valid drops.
  - The next accept can occur in the cycle after DONE exits, not in the same cycle.
- Store lane steering:
  - off = addr[log2(NBYTES)-1:0].
  - req_wdata = in_wdata << (8*off).
  - req_wstrb = ((1<<sz)-1) << off.
  - req_addr = addr with the low log2(NBYTES) bits cleared.
- Load extraction:
  - Select resp_rdata >> (8*off), take sz bytes.
  - Signed ops sign-extend to DATA_W; U ops zero-extend.
  - Loads drive req_we=0 and req_wstrb=0.
- Out fields:
  - out_ale=1 and out_badv=addr for misaligned ops, with out_rdata=0.
  - For all other ops, out_badv=0.
- Latency with a zero-wait bus (req_ready=1, resp_valid in the cycle after handshake): accept at T, req at T+1, resp at T+2, out_valid at T+3.
- Reset (rst_n=0 at a clk edge, including mid-operation):
  - FSM returns to IDLE and all registered state clears.
  - Outputs: req_valid=0, out_valid=0, out_ale=0, out_rdata=0, out_badv=0, busy=0, req_we=0, req_wstrb=0, req_addr=0, req_wdata=0, in_ready=1.
  - A bus response that arrives after reset is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - the op-code localparams;
  - the state enum;
  - a function op_size(op) -> bytes;
  - a function op_is_store/op_is_unsigned.
- One sub-module, lsu_align: purely combinational, parametrised by DATA_W.
  - Store path: addr offset, size, data -> wdata/wstrb.
  - Load path: rdata, offset, size, signed -> extended data.
  - It is instantiated once and used for both paths.

Test Plan:
- DATA_W=32, ST.H addr=0x1002 wdata=0x0000BEEF -> req_addr=0x1000, req_wstrb=4'b1100, req_wdata=0xBEEF0000, req_we=1; out_valid after resp, out_rdata=0.
- DATA_W=32, LD.B addr=0x2003 resp_rdata=0x80000000 -> out_rdata=0xFFFFFF80. LD.BU at the same address -> 0x00000080. Zero-wait latency is exactly 3 cycles from accept.
- LD.W addr=0x3002 -> no req_valid ever asserted; out_valid=1, out_ale=1, out_badv=0x3002 one cycle after accept.
- req_ready held 0 for 4 cycles -> req_* stable throughout. in_flush in RESP, resp_valid 2 cycles later -> out_valid never asserts, then in_ready returns to 1.
- DATA_W=64, LD.WU addr=0x4004 resp_rdata=0xDEADBEEF_00000000 -> out_rdata=0x00000000_DEADBEEF. ST.D addr=0x4004 -> out_ale=1.
- rst_n=0 asserted in RESP -> next cycle busy=0, in_ready=1, out_valid=0; a late resp_valid is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: op codes, FSM state codes and op-decode helpers
// shared by the load/store unit and its lane aligner.
package lsu_pkg;

  localparam logic [3:0] OP_LD_B  = 4'b0000;
  localparam logic [3:0] OP_LD_H  = 4'b0001;
  localparam logic [3:0] OP_LD_W  = 4'b0010;
  localparam logic [3:0] OP_LD_D  = 4'b0011;
  localparam logic [3:0] OP_LD_BU = 4'b1000;
  localparam logic [3:0] OP_LD_HU = 4'b1001;
  localparam logic [3:0] OP_LD_WU = 4'b1010;
  localparam logic [3:0] OP_ST_B  = 4'b0100;
  localparam logic [3:0] OP_ST_H  = 4'b0101;
  localparam logic [3:0] OP_ST_W  = 4'b0110;
  localparam logic [3:0] OP_ST_D  = 4'b0111;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // Access size in bytes: 1/2/4/8 from the low two op bits.
  function automatic logic [3:0] op_size(input logic [3:0] op);
    return 4'd1 << op[1:0];
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return op[3:2] == 2'b01;
  endfunction

  function automatic logic op_is_unsigned(input logic [3:0] op);
    return op[3];
  endfunction

  // Real memory op? Doubleword forms only exist on a 64-bit datapath.
  function automatic logic op_is_mem(input logic [3:0] op,
                                     input logic wide);
    logic r;
    case (op)
      OP_LD_B, OP_LD_H, OP_LD_W,
      OP_LD_BU, OP_LD_HU,
      OP_ST_B, OP_ST_H, OP_ST_W: r = 1'b1;
      OP_LD_D, OP_LD_WU, OP_ST_D: r = wide;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and
// extraction plus sign/zero extension for loads.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NBYTES = DATA_W / 8,
  localparam int OFF_W = $clog2(NBYTES),
  localparam int MSB_W = $clog2(DATA_W)
) (
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        lg,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] st_wdata,
  output logic [NBYTES-1:0] st_wstrb,
  input  logic [DATA_W-1:0] ld_rdata,
  input  logic              ld_unsigned,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] ld_sh;
  logic [MSB_W-1:0]  msb;
  logic              sgn;
  int                nb;

  // Shift store data up to its lane, shift load data down and extend.
  always_comb begin
    nb = 1 << lg;
    st_wdata = st_data << {off, 3'b000};
    st_wstrb = '0;
    ld_sh = ld_rdata >> {off, 3'b000};
    msb = MSB_W'((8 << lg) - 1);
    sgn = ~ld_unsigned & ld_sh[msb];
    ld_data = '0;
    for (int i = 0; i < NBYTES; i++) begin
      st_wstrb[i] = (i >= int'(off)) && (i < int'(off) + nb);
      ld_data[8*i +: 8] = (i < nb) ? ld_sh[8*i +: 8] : {8{sgn}};
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit with one outstanding
// bus access, misalignment detection and extended load results.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int NBYTES = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_lsu_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_flush,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [NBYTES-1:0] req_wstrb,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_ale,
  output logic [ADDR_W-1:0] out_badv,
  output logic              busy
);

  localparam int OFF_W = $clog2(NBYTES);
  localparam logic WIDE = (DATA_W == 64);

  logic [2:0]        state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ale_q;

  logic              is_mem;
  logic              mis;
  logic              st_q;
  logic [DATA_W-1:0] al_wdata;
  logic [NBYTES-1:0] al_wstrb;
  logic [DATA_W-1:0] al_ldata;

  assign is_mem = op_is_mem(in_lsu_op, WIDE);
  assign mis = is_mem &&
    ((in_addr[2:0] & 3'(op_size(in_lsu_op) - 4'd1)) != 3'd0);
  assign st_q = op_is_store(op_q);

  assign in_ready  = state == S_IDLE;
  assign busy      = state != S_IDLE;
  assign req_valid = state == S_REQ;
  assign req_we    = req_valid & st_q;
  assign req_addr  = req_valid ?
    {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign req_wdata = req_we ? al_wdata : '0;
  assign req_wstrb = req_we ? al_wstrb : '0;
  assign out_valid = state == S_DONE;
  assign out_rdata = out_valid ? rdata_q : '0;
  assign out_ale   = out_valid & ale_q;
  assign out_badv  = out_ale ? addr_q : '0;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .off         (addr_q[OFF_W-1:0]),
    .lg          (op_q[1:0]),
    .st_data     (wdata_q),
    .st_wdata    (al_wdata),
    .st_wstrb    (al_wstrb),
    .ld_rdata    (resp_rdata),
    .ld_unsigned (op_is_unsigned(op_q)),
    .ld_data     (al_ldata)
  );

  // Access sequencing: accept, request, response, result hand-off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ale_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= in_lsu_op;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            rdata_q <= '0;
            ale_q   <= mis;
            state   <= (is_mem && !mis) ? S_REQ : S_DONE;
          end
        end
        S_REQ: begin
          if (in_flush)       state <= S_IDLE;
          else if (req_ready) state <= S_RESP;
        end
        S_RESP: begin
          if (resp_valid && in_flush) begin
            state <= S_IDLE;
          end else if (resp_valid) begin
            rdata_q <= st_q ? '0 : al_ldata;
            state   <= S_DONE;
          end else if (in_flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (resp_valid) state <= S_IDLE;
        end
        S_DONE: begin
          if (in_flush || out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized load/store traffic against a
// transaction-level model, plus directed 32- and 64-bit cases.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, in_ready, in_flush;
  logic [3:0]  in_lsu_op;
  logic [31:0] in_addr, in_wdata;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        out_valid, out_ready, out_ale, busy;
  logic [31:0] out_rdata, out_badv;

  lsu_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lsu_op(in_lsu_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_flush(in_flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_ale(out_ale),
    .out_badv(out_badv), .busy(busy)
  );

  // 64-bit instance
  logic        v64, irdy64, fl64;
  logic [3:0]  op64;
  logic [31:0] a64;
  logic [63:0] wd64;
  logic        rv64, rrdy64, we64;
  logic [31:0] ra64;
  logic [63:0] rwd64;
  logic [7:0]  strb64;
  logic        rsv64;
  logic [63:0] rd64;
  logic        ov64, ordy64, ale64, busy64;
  logic [63:0] ord64;
  logic [31:0] badv64;

  lsu_ctrl #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v64), .in_ready(irdy64),
    .in_lsu_op(op64), .in_addr(a64),
    .in_wdata(wd64), .in_flush(fl64),
    .req_valid(rv64), .req_ready(rrdy64),
    .req_we(we64), .req_addr(ra64),
    .req_wdata(rwd64), .req_wstrb(strb64),
    .resp_valid(rsv64), .resp_rdata(rd64),
    .out_valid(ov64), .out_ready(ordy64),
    .out_rdata(ord64), .out_ale(ale64),
    .out_badv(badv64), .busy(busy64)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, set by the driver
  bit          chk_en = 0;
  bit          e_rst;
  logic        e_in_ready, e_busy, e_req_valid, e_out_valid;
  logic        e_req_we, e_out_ale;
  logic [31:0] e_req_addr, e_req_wdata, e_out_rdata, e_out_badv;
  logic [3:0]  e_req_wstrb;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, e_in_ready);
      chk("busy", busy, e_busy);
      chk("req_valid", req_valid, e_req_valid);
      chk("out_valid", out_valid, e_out_valid);
      if (e_req_valid) begin
        chk("req_we", req_we, e_req_we);
        chk("req_addr", req_addr, e_req_addr);
        chk("req_wstrb", req_wstrb, e_req_wstrb);
        if (e_req_we) chk("req_wdata", req_wdata, e_req_wdata);
      end
      if (e_out_valid) begin
        chk("out_rdata", out_rdata, e_out_rdata);
        chk("out_ale", out_ale, e_out_ale);
        chk("out_badv", out_badv, e_out_badv);
      end
      if (e_rst) begin
        chk("rst_req_we", req_we, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_wdata", req_wdata, 0);
        chk("rst_req_wstrb", req_wstrb, 0);
        chk("rst_out_rdata", out_rdata, 0);
        chk("rst_out_ale", out_ale, 0);
        chk("rst_out_badv", out_badv, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic x_idle();
    e_in_ready = 1; e_busy = 0;
    e_req_valid = 0; e_out_valid = 0; e_req_we = 0;
  endtask

  task automatic x_quiet();
    e_in_ready = 0; e_busy = 1;
    e_req_valid = 0; e_out_valid = 0; e_req_we = 0;
  endtask

  // Codes that are real accesses on a 32-bit datapath
  function automatic bit op_ok(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h8, 4'h9,
      4'h4, 4'h5, 4'h6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Take sz bytes starting at byte off, then sign- or zero-extend
  function automatic logic [31:0] ext32(input logic [31:0] rd,
    input int off, input int sz, input bit uns);
    longint unsigned v, m;
    m = (64'd1 << (8 * sz)) - 64'd1;
    v = 64'(rd >> (8 * off)) & m;
    if (!uns && v[8*sz-1]) v = v | ~m;
    return v[31:0];
  endfunction

  // fm: 0 normal, 1 flush in REQ, 2 flush in RESP then late resp,
  //     3 flush with resp, 4 flush in DONE
  task automatic run_op(input logic [3:0] op,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] rd, input int wreq, input int wresp,
    input int fm, input int hold, input bit lit,
    input logic [31:0] l_rd, input logic [31:0] l_addr,
    input logic [31:0] l_wd, input logic [3:0] l_strb);
    bit known, st, uns, mis;
    int sz, off;
    logic [31:0] res;
    known = op_ok(op);
    st = (op[3:2] == 2'b01);
    uns = op[3];
    sz = 1 << op[1:0];
    off = int'(a % 4);
    mis = known && ((a % sz) != 0);
    res = (!known || mis || st) ? 32'h0 : ext32(rd, off, sz, uns);
    in_valid = 1; in_lsu_op = op; in_addr = a; in_wdata = wd;
    tick();
    in_valid = 0; in_lsu_op = 4'($urandom);
    in_addr = $urandom; in_wdata = $urandom;
    e_rst = 0;
    if (known && !mis) begin
      x_quiet();
      e_req_valid = 1;
      e_req_we = st;
      e_req_addr = a & ~32'h3;
      e_req_wstrb = st ? 4'(((1 << sz) - 1) << off) : 4'h0;
      e_req_wdata = wd << (8 * off);
      if (lit) begin
        chk("lit_req_addr", req_addr, l_addr);
        chk("lit_req_wstrb", req_wstrb, l_strb);
        if (st) chk("lit_req_wdata", req_wdata, l_wd);
      end
      for (int i = 0; i < wreq; i++) tick();
      if (fm == 1) begin
        in_flush = 1; req_ready = 1'($urandom);
        tick();
        in_flush = 0; req_ready = 0;
        x_idle();
        return;
      end
      req_ready = 1;
      tick();
      req_ready = 0;
      x_quiet();
      for (int i = 0; i < wresp; i++) tick();
      if (fm == 2) begin
        in_flush = 1;
        tick();
        in_flush = 0;
        tick();
        resp_valid = 1; resp_rdata = $urandom;
        tick();
        resp_valid = 0;
        x_idle();
        return;
      end
      resp_valid = 1; resp_rdata = rd;
      if (fm == 3) begin
        in_flush = 1;
        tick();
        in_flush = 0; resp_valid = 0;
        x_idle();
        return;
      end
      tick();
      resp_valid = 0; resp_rdata = $urandom;
    end
    x_quiet();
    e_out_valid = 1;
    e_out_rdata = res;
    e_out_ale = mis;
    e_out_badv = mis ? a : 32'h0;
    if (lit) chk("lit_out_rdata", out_rdata, l_rd);
    // Offer a new op while DONE; it must not be taken yet
    in_valid = 1'($urandom); in_lsu_op = 4'($urandom);
    for (int i = 0; i < hold; i++) tick();
    if (fm == 4) in_flush = 1;
    else out_ready = 1;
    tick();
    in_flush = 0; out_ready = 0; in_valid = 0;
    x_idle();
  endtask

  // Reset while a load waits for its response; a late resp is ignored
  task automatic rst_mid();
    in_valid = 1; in_lsu_op = 4'h2; in_addr = 32'h5000;
    tick();
    in_valid = 0; e_rst = 0;
    x_quiet();
    e_req_valid = 1; e_req_addr = 32'h5000; e_req_wstrb = 4'h0;
    req_ready = 1;
    tick();
    req_ready = 0;
    x_quiet();
    rst_n = 0;
    tick();
    rst_n = 1;
    x_idle(); e_rst = 1;
    resp_valid = 1; resp_rdata = 32'h1234_5678;
    tick();
    resp_valid = 0;
    tick();
    tick();
  endtask

  task automatic run64(input logic [3:0] op, input logic [31:0] a,
    input logic [63:0] wd, input logic [63:0] rd, input bit ale,
    input logic [63:0] l_rd, input logic [7:0] l_strb);
    v64 = 1; op64 = op; a64 = a; wd64 = wd;
    tick();
    v64 = 0;
    if (!ale) begin
      chk("w64_req_valid", rv64, 1);
      chk("w64_req_wstrb", strb64, l_strb);
      tick();
      rsv64 = 1; rd64 = rd;
      tick();
      rsv64 = 0;
    end
    chk("w64_out_valid", ov64, 1);
    chk("w64_out_ale", ale64, ale);
    chk("w64_out_badv", badv64, ale ? a : 32'h0);
    chk("w64_out_rdata", ord64, l_rd);
    ordy64 = 1;
    tick();
    ordy64 = 0;
    chk("w64_in_ready", irdy64, 1);
  endtask

  initial begin
    rst_n = 0;
    in_valid = 0; in_lsu_op = 0; in_addr = 0; in_wdata = 0;
    in_flush = 0; req_ready = 0; resp_valid = 0; resp_rdata = 0;
    out_ready = 0;
    v64 = 0; op64 = 0; a64 = 0; wd64 = 0; fl64 = 0;
    rrdy64 = 1; rsv64 = 0; rd64 = 0; ordy64 = 0;
    e_req_addr = 0; e_req_wdata = 0; e_req_wstrb = 0;
    e_out_rdata = 0; e_out_ale = 0; e_out_badv = 0;
    tick();
    x_idle(); e_rst = 1; chk_en = 1;
    tick();
    rst_n = 1;
    tick();

    // ST.H lane steering
    run_op(4'h5, 32'h1002, 32'h0000_BEEF, 32'h0, 0, 0, 0, 0,
           1, 32'h0, 32'h1000, 32'hBEEF_0000, 4'b1100);
    // LD.B / LD.BU at the top byte, zero-wait bus
    run_op(4'h0, 32'h2003, 32'h0, 32'h8000_0000, 0, 0, 0, 0,
           1, 32'hFFFF_FF80, 32'h2000, 32'h0, 4'h0);
    run_op(4'h8, 32'h2003, 32'h0, 32'h8000_0000, 0, 0, 0, 0,
           1, 32'h0000_0080, 32'h2000, 32'h0, 4'h0);
    // Misaligned LD.W: no bus request
    run_op(4'h2, 32'h3002, 32'h0, 32'h0, 0, 0, 0, 1,
           1, 32'h0, 32'h0, 32'h0, 4'h0);
    // Request stalled four cycles
    run_op(4'h6, 32'h3008, 32'hCAFE_F00D, 32'h0, 4, 0, 0, 0,
           1, 32'h0, 32'h3008, 32'hCAFE_F00D, 4'hF);
    // Flush in RESP, response two cycles later
    run_op(4'h1, 32'h3010, 32'h0, 32'h0, 0, 0, 2, 0,
           0, 32'h0, 32'h0, 32'h0, 4'h0);
    rst_mid();

    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom % 10);
      run_op(4'($urandom), $urandom, $urandom, $urandom,
             int'($urandom % 4), int'($urandom % 3),
             (r < 6) ? 0 : r - 5, int'($urandom % 3),
             0, 32'h0, 32'h0, 32'h0, 4'h0);
      if ($urandom % 3 == 0) tick();
    end
    rst_mid();

    chk_en = 0;
    run64(4'hA, 32'h4004, 64'h0, 64'hDEAD_BEEF_0000_0000, 0,
          64'h0000_0000_DEAD_BEEF, 8'h00);
    run64(4'h2, 32'h4004, 64'h0, 64'h8000_0000_0000_0000, 0,
          64'hFFFF_FFFF_8000_0000, 8'h00);
    run64(4'h1, 32'h4006, 64'h0, 64'h8001_0000_0000_0000, 0,
          64'hFFFF_FFFF_FFFF_8001, 8'h00);
    run64(4'h3, 32'h4000, 64'h0, 64'h0123_4567_89AB_CDEF, 0,
          64'h0123_4567_89AB_CDEF, 8'h00);
    run64(4'h7, 32'h4004, 64'h1, 64'h0, 1, 64'h0, 8'h00);
    run64(4'h7, 32'h4008, 64'h1, 64'h0, 0, 64'h0, 8'hFF);
    run64(4'h6, 32'h400C, 64'h1, 64'h0, 0, 64'h0, 8'hF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
